// File: rtl/nasti_stream_pkg.sv
// Shared constants and helpers for the NASTI-stream buffer family.
package nasti_stream_pkg;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Byte-lane count for a given data width.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// NASTI-stream (AXI-stream style) channel bundle with master/slave views.
interface nasti_stream_channel
  import nasti_stream_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 64
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  logic                  t_valid;
  logic                  t_ready;
  logic [DATA_WIDTH-1:0] t_data;
  logic [STRB_WIDTH-1:0] t_strb;
  logic [STRB_WIDTH-1:0] t_keep;
  logic                  t_last;
  logic [ID_WIDTH-1:0]   t_id;
  logic [DEST_WIDTH-1:0] t_dest;
  logic [USER_WIDTH-1:0] t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );

endinterface

// File: rtl/stream_ram_fifo.sv
// Flop-array FIFO with explicitly wrapping pointers, level counter and
// registered almost-full flag. Depth need not be a power of two.
module stream_ram_fifo
  import nasti_stream_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_THRESH = DEPTH - 2
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [clog2p1(DEPTH)-1:0]   level,
  output logic                        almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = clog2p1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_next;

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap at DEPTH-1 by compare so any depth works.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // Next occupancy: concurrent push and pop cancel.
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  // Registered occupancy and almost-full derived from the same next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_next;
      almost_full <= (level_next >= LVL_W'(AFULL_THRESH));
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/nasti_stream_pkt_buf.sv
// NASTI-stream elastic packet buffer: cut-through or store-and-forward with
// a forced flush for packets larger than the buffer.
// Optional statistics counters: define NASTI_STREAM_PKT_BUF_STATS_EN.
module nasti_stream_pkt_buf
  import nasti_stream_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 1,
  parameter int unsigned DEST_WIDTH   = 1,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BUF_SIZE     = 8,
  parameter int unsigned PKT_MODE     = 0,
  parameter int unsigned AFULL_THRESH = BUF_SIZE - 2
)(
  input  logic                           aclk,
  input  logic                           areset,
  nasti_stream_channel.slave             src,
  nasti_stream_channel.master            dest,
  output logic [clog2p1(BUF_SIZE)-1:0]   level,
  output logic [clog2p1(BUF_SIZE)-1:0]   pkt_count,
  output logic                           almost_full
`ifdef NASTI_STREAM_PKT_BUF_STATS_EN
  ,
  output logic [31:0]                    stat_beats,
  output logic [31:0]                    stat_pkts
`endif
);

  localparam int unsigned LVL_W   = clog2p1(BUF_SIZE);
  localparam int unsigned STRB_W  = strb_width(DATA_WIDTH);
  localparam int unsigned ENTRY_W = DATA_WIDTH + 2 * STRB_W + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam bit          PKT_EN  = (PKT_MODE != 0);

  logic                  push;
  logic                  pop;
  logic                  src_ready_c;
  logic                  dest_valid_c;
  logic                  flush;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [STRB_W-1:0]     rd_strb;
  logic [STRB_W-1:0]     rd_keep;
  logic                  rd_last;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [DEST_WIDTH-1:0] rd_dest;
  logic [USER_WIDTH-1:0] rd_user;

  assign wr_entry = {src.t_data, src.t_strb, src.t_keep, src.t_last,
                     src.t_id, src.t_dest, src.t_user};
  assign {rd_data, rd_strb, rd_keep, rd_last, rd_id, rd_dest, rd_user} = rd_entry;

  stream_ram_fifo #(
    .WIDTH        (ENTRY_W),
    .DEPTH        (BUF_SIZE),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_fifo (
    .clk         (aclk),
    .rst         (areset),
    .push        (push),
    .pop         (pop),
    .wdata       (wr_entry),
    .rdata       (rd_entry),
    .level       (level),
    .almost_full (almost_full)
  );

  // Ready depends only on stored state, never on dest.t_ready.
  assign src_ready_c  = !areset && (level != LVL_W'(BUF_SIZE));
  assign push         = src.t_valid && src_ready_c;
  // In packet mode hold output until a whole packet is in, unless flushing.
  assign dest_valid_c = !areset && (level != '0) &&
                        (!PKT_EN || (pkt_count != '0) || flush);
  assign pop          = dest_valid_c && dest.t_ready;

  assign src.t_ready  = src_ready_c;
  assign dest.t_valid = dest_valid_c;
  assign dest.t_data  = rd_data;
  assign dest.t_strb  = rd_strb;
  assign dest.t_keep  = rd_keep;
  assign dest.t_last  = rd_last;
  assign dest.t_id    = rd_id;
  assign dest.t_dest  = rd_dest;
  assign dest.t_user  = rd_user;

  // Count complete packets (t_last beats) currently stored.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_count <= '0;
    end else begin
      case ({push && src.t_last, pop && rd_last})
        2'b10:   pkt_count <= pkt_count + LVL_W'(1);
        2'b01:   pkt_count <= pkt_count - LVL_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Full with no complete packet means it can never complete: drain it cut-through.
  always_ff @(posedge aclk) begin
    if (areset || !PKT_EN) begin
      flush <= 1'b0;
    end else if (pop && rd_last) begin
      flush <= 1'b0;
    end else if ((level == LVL_W'(BUF_SIZE)) && (pkt_count == '0)) begin
      flush <= 1'b1;
    end
  end

`ifdef NASTI_STREAM_PKT_BUF_STATS_EN
  // Free-running output beat and packet counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else begin
      if (pop)            stat_beats <= stat_beats + 32'(1);
      if (pop && rd_last) stat_pkts  <= stat_pkts + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nasti_stream_pkt_buf.sv
// Bench for nasti_stream_pkt_buf: three configurations side by side
// (cut-through depth 5, store-and-forward depth 8, store-and-forward depth 4).
module tb_nasti_stream_pkt_buf;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic        id;
    logic        dest;
    logic        user;
  } beat_t;

  typedef struct {
    int k;
    bit push;
    bit last;
    bit rdy;
    int lvl;
    int pkt;
    bit srdy;
    bit af;
    bit dv;
  } vec_t;

  function automatic int unsigned bs_of(input int g);
    return (g == 0) ? 5 : (g == 1) ? 8 : 4;
  endfunction
  function automatic int unsigned pm_of(input int g);
    return (g == 0) ? 0 : 1;
  endfunction
  function automatic int unsigned af_of(input int g);
    return (g == 0) ? 3 : bs_of(g) - 2;
  endfunction

  logic clk;
  logic rst [3];
  logic sv [3];
  logic dr [3];
  beat_t sb [3];
  logic srdy [3];
  logic dv [3];
  beat_t ob [3];
  logic [7:0] lvl [3];
  logic [7:0] pkt [3];
  logic af [3];
`ifdef NASTI_STREAM_PKT_BUF_STATS_EN
  logic [31:0] stb [3];
  logic [31:0] stp [3];
`endif

  int n_vec;
  int n_err;
  beat_t q [3][$];
  int unsigned seq [3];
  int unsigned popped [3];
  beat_t held [3];
  bit hold_v [3];
  vec_t tv [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    nasti_stream_channel #(.DATA_WIDTH(DW)) s_if ();
    nasti_stream_channel #(.DATA_WIDTH(DW)) d_if ();
    logic [$clog2(bs_of(g) + 1)-1:0] lv;
    logic [$clog2(bs_of(g) + 1)-1:0] pc;

    assign s_if.t_valid = sv[g];
    assign s_if.t_data  = sb[g].data;
    assign s_if.t_strb  = sb[g].strb;
    assign s_if.t_keep  = sb[g].keep;
    assign s_if.t_last  = sb[g].last;
    assign s_if.t_id    = sb[g].id;
    assign s_if.t_dest  = sb[g].dest;
    assign s_if.t_user  = sb[g].user;
    assign d_if.t_ready = dr[g];
    assign srdy[g] = s_if.t_ready;
    assign dv[g]   = d_if.t_valid;
    assign ob[g]   = {d_if.t_data, d_if.t_strb, d_if.t_keep, d_if.t_last,
                      d_if.t_id, d_if.t_dest, d_if.t_user};
    assign lvl[g]  = 8'(lv);
    assign pkt[g]  = 8'(pc);

    nasti_stream_pkt_buf #(
      .DATA_WIDTH   (DW),
      .BUF_SIZE     (bs_of(g)),
      .PKT_MODE     (pm_of(g)),
      .AFULL_THRESH (af_of(g))
    ) u_dut (
      .aclk        (clk),
      .areset      (rst[g]),
      .src         (s_if),
      .dest        (d_if),
      .level       (lv),
      .pkt_count   (pc),
      .almost_full (af[g])
`ifdef NASTI_STREAM_PKT_BUF_STATS_EN
      ,
      .stat_beats  (stb[g]),
      .stat_pkts   (stp[g])
`endif
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input int k, input int unsigned s, input bit last);
    beat_t b;
    b.data = {8'(k), 24'(s)};
    b.strb = 4'(s);
    b.keep = ~4'(s >> 2);
    b.last = last;
    b.id   = s[0];
    b.dest = s[1];
    b.user = s[2];
    return b;
  endfunction

  function automatic void add(input int k, input bit push, input bit last, input bit rdy,
                              input int lv, input int pc, input bit sr, input bit a, input bit v);
    vec_t t;
    t.k = k; t.push = push; t.last = last; t.rdy = rdy;
    t.lvl = lv; t.pkt = pc; t.srdy = sr; t.af = a; t.dv = v;
    tv.push_back(t);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit push, input bit last, input bit rdy);
    sv[k] = push;
    sb[k] = mk(k, seq[k], last);
    dr[k] = rdy;
  endtask

  // Scoreboard: capture handshakes that will complete on the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        q[k].delete();
        hold_v[k] = 1'b0;
      end else begin
        if (sv[k] && srdy[k]) begin
          q[k].push_back(sb[k]);
          seq[k]++;
        end
        if (dv[k] && hold_v[k])
          chk($sformatf("stable_payload_%0d", k), 64'(ob[k]), 64'(held[k]));
        if (dv[k] && dr[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("pop_on_empty_sb_%0d", k), 64'(ob[k]), 64'hDEAD_0000_0000_0000);
          end else begin
            chk($sformatf("order_%0d_beat%0d", k, popped[k]), 64'(ob[k]), 64'(q[k].pop_front()));
          end
          popped[k]++;
          hold_v[k] = 1'b0;
        end else if (dv[k]) begin
          hold_v[k] = 1'b1;
          held[k]   = ob[k];
        end else begin
          hold_v[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    vec_t v;
    int unsigned base;
    int unsigned p;
    int n;
    int mlvl;
    bit pp, po, rv, rr;

    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      seq[k] = 0;
      popped[k] = 0;
      hold_v[k] = 1'b0;
      drive(k, 1'b0, 1'b0, 1'b0);
    end

    // Reset state.
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_level_%0d", k), 64'(lvl[k]), 64'd0);
      chk($sformatf("rst_pkt_%0d", k), 64'(pkt[k]), 64'd0);
      chk($sformatf("rst_af_%0d", k), 64'(af[k]), 64'd0);
      chk($sformatf("rst_dv_%0d", k), 64'(dv[k]), 64'd0);
      chk($sformatf("rst_srdy_%0d", k), 64'(srdy[k]), 64'd0);
    end
    cyc();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Cut-through depth 5: fill, hold full with pop pending, drain.
    add(0, 1, 0, 0, 0, -1, 1, 0, 0);
    add(0, 1, 0, 0, 1, -1, 1, 0, 1);
    add(0, 1, 0, 0, 2, -1, 1, 0, 1);
    add(0, 1, 0, 0, 3, -1, 1, 1, 1);
    add(0, 1, 1, 0, 4, -1, 1, 1, 1);
    add(0, 0, 0, 0, 5, -1, 0, 1, 1);
    add(0, 1, 0, 1, 5, -1, 0, 1, 1);
    add(0, 0, 0, 1, 4, -1, 1, 1, 1);
    add(0, 0, 0, 1, 3, -1, 1, 1, 1);
    add(0, 0, 0, 1, 2, -1, 1, 0, 1);
    add(0, 0, 0, 1, 1, -1, 1, 0, 1);
    add(0, 0, 0, 0, 0, -1, 1, 0, 0);
    // Store-and-forward depth 8: 3-beat packet held until its last beat lands.
    add(1, 1, 0, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0, 1, 0, 0);
    add(1, 1, 1, 1, 2, 0, 1, 0, 0);
    add(1, 0, 0, 1, 3, 1, 1, 0, 1);
    add(1, 0, 0, 1, 2, 1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      drive(v.k, v.push, v.last, v.rdy);
      #1;
      chk($sformatf("tv%0d_level", i), 64'(lvl[v.k]), 64'(v.lvl));
      if (v.pkt >= 0) chk($sformatf("tv%0d_pkt", i), 64'(pkt[v.k]), 64'(v.pkt));
      chk($sformatf("tv%0d_srdy", i), 64'(srdy[v.k]), 64'(v.srdy));
      chk($sformatf("tv%0d_af", i), 64'(af[v.k]), 64'(v.af));
      chk($sformatf("tv%0d_dv", i), 64'(dv[v.k]), 64'(v.dv));
      cyc();
    end

    // Oversize 6-beat packet into depth 4 store-and-forward.
    base = seq[2];
    p = popped[2];
    n = 0;
    while (lvl[2] != 8'd4 && n < 10) begin
      drive(2, 1'b1, (seq[2] - base) == 5, 1'b0);
      cyc();
      n++;
    end
    drive(2, 1'b1, (seq[2] - base) == 5, 1'b0);
    #1;
    chk("ovs_full_level", 64'(lvl[2]), 64'd4);
    chk("ovs_full_dv", 64'(dv[2]), 64'd0);
    chk("ovs_full_flush", 64'(gen_dut[2].u_dut.flush), 64'd0);
    cyc();
    chk("ovs_flush_dv", 64'(dv[2]), 64'd1);
    chk("ovs_flush_set", 64'(gen_dut[2].u_dut.flush), 64'd1);
    n = 0;
    while (!((seq[2] - base) == 6 && lvl[2] == 8'd0) && n < 40) begin
      drive(2, (seq[2] - base) < 6, (seq[2] - base) == 5, 1'b1);
      cyc();
      n++;
    end
    drive(2, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ovs_drain_in_time", 64'(n < 40), 64'd1);
    chk("ovs_beats_out", 64'(popped[2] - p), 64'd6);
    chk("ovs_flush_clear", 64'(gen_dut[2].u_dut.flush), 64'd0);
    chk("ovs_pkt", 64'(pkt[2]), 64'd0);
    chk("ovs_dv", 64'(dv[2]), 64'd0);
    chk("ovs_sb_empty", 64'(q[2].size()), 64'd0);
    cyc();

    // Random concurrent traffic around level 2 on the cut-through buffer.
    p = popped[0];
    mlvl = 0;
    pp = 1'b0;
    po = 1'b0;
    n = 0;
    while ((popped[0] - p) < 1000 && n < 20000) begin
      mlvl = mlvl + int'(pp) - int'(po);
      chk("rnd_level", 64'(lvl[0]), 64'(mlvl));
      rv = (n < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rr = (n < 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      drive(0, rv, $urandom_range(0, 2) == 0, rr);
      #1;
      chk("rnd_srdy", 64'(srdy[0]), 64'(mlvl != 5));
      chk("rnd_dv", 64'(dv[0]), 64'(mlvl != 0));
      pp = rv && (mlvl != 5);
      po = rr && (mlvl != 0);
      cyc();
      n++;
    end
    chk("rnd_in_time", 64'(n < 20000), 64'd1);
    n = 0;
    while (lvl[0] != 8'd0 && n < 20) begin
      drive(0, 1'b0, 1'b0, 1'b1);
      cyc();
      n++;
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rnd_drained", 64'(lvl[0]), 64'd0);
    chk("rnd_sb_empty", 64'(q[0].size()), 64'd0);
    chk("rnd_accounting", 64'(seq[0]), 64'(popped[0]));
    cyc();

    // Reset with three beats (one complete packet) stored.
    drive(1, 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_pre_level", 64'(lvl[1]), 64'd3);
    chk("mid_pre_pkt", 64'(pkt[1]), 64'd1);
    chk("mid_pre_dv", 64'(dv[1]), 64'd1);
    rst[1] = 1'b1;
    #1;
    chk("mid_rst_srdy", 64'(srdy[1]), 64'd0);
    chk("mid_rst_dv", 64'(dv[1]), 64'd0);
    cyc();
    rst[1] = 1'b0;
    #1;
    chk("mid_post_level", 64'(lvl[1]), 64'd0);
    chk("mid_post_pkt", 64'(pkt[1]), 64'd0);
    chk("mid_post_dv", 64'(dv[1]), 64'd0);
    p = popped[1];
    drive(1, 1'b1, 1'b0, 1'b1);
    cyc();
    drive(1, 1'b1, 1'b1, 1'b1);
    cyc();
    n = 0;
    while (!((popped[1] - p) == 2 && lvl[1] == 8'd0) && n < 20) begin
      drive(1, 1'b0, 1'b0, 1'b1);
      cyc();
      n++;
    end
    chk("mid_next_beats", 64'(popped[1] - p), 64'd2);
    chk("mid_next_sb_empty", 64'(q[1].size()), 64'd0);
    chk("mid_next_pkt", 64'(pkt[1]), 64'd0);

`ifdef NASTI_STREAM_PKT_BUF_STATS_EN
    // Statistics: four 2-beat packets, cleared by reset.
    drive(1, 1'b0, 1'b0, 1'b0);
    rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    #1;
    chk("stat_rst_beats", 64'(stb[1]), 64'd0);
    chk("stat_rst_pkts", 64'(stp[1]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b0, 1'b1);
      cyc();
      drive(1, 1'b1, 1'b1, 1'b1);
      cyc();
    end
    n = 0;
    while (lvl[1] != 8'd0 && n < 20) begin
      drive(1, 1'b0, 1'b0, 1'b1);
      cyc();
      n++;
    end
    drive(1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("stat_beats", 64'(stb[1]), 64'd8);
    chk("stat_pkts", 64'(stp[1]), 64'd4);
    rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    #1;
    chk("stat_clr_beats", 64'(stb[1]), 64'd0);
    chk("stat_clr_pkts", 64'(stp[1]), 64'd0);
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nasti_stream_pkt_buf.md
Name: nasti_stream_pkt_buf

Overview:
- Second-generation NASTI-stream elastic buffer between a `nasti_stream_channel` slave (`src`) and master (`dest`).
- Adds the following:
  - Full AXI-stream handshake on both sides: a beat moves only on valid && ready.
  - Arbitrary (non-power-of-2) depth.
  - Occupancy and packet-count outputs.
  - Store-and-forward packet mode with a forced-flush escape for oversize packets.
- Used in front of DMA and stream-to-memory bridges that need whole packets before starting a burst.

Parameters:
- ID_WIDTH, 1, width of t_id
- DEST_WIDTH, 1, width of t_dest
- USER_WIDTH, 1, width of t_user
- DATA_WIDTH, 64, t_data width; multiple of 8; t_strb/t_keep are DATA_WIDTH/8
- BUF_SIZE, 8, entries; any integer >= 2
- PKT_MODE, 0, 0 = cut-through; 1 = store-and-forward
- AFULL_THRESH, BUF_SIZE-2, level at or above which almost_full asserts; range 1..BUF_SIZE

Ports:
- aclk  input  1  clock; all logic on the rising edge
- areset  input  1  synchronous, active-high reset
- src  nasti_stream_channel.slave  interface  input stream
- dest  nasti_stream_channel.master  interface  output stream
- level  output  $clog2(BUF_SIZE+1)  entries currently stored
- pkt_count  output  $clog2(BUF_SIZE+1)  complete packets (t_last stored) currently held
- almost_full  output  1  level >= AFULL_THRESH

Behaviour:
- Clocking and reset are fixed:
  - One clock, `aclk`.
  - `areset` is synchronous and active-high.
- While `areset` is high, or in the cycle after it is sampled high:
  - level = 0, pkt_count = 0, almost_full = 0.
  - dest.t_valid = 0, src.t_ready = 0 while areset is high.
  - Write/read pointers = 0; flush flag = 0.
  - Storage contents are don't-care.
- Reset mid-packet discards all stored beats. No partial state survives.
- Storage:
  - Flop array of BUF_SIZE entries.
  - Each entry holds {data, strb, keep, last, id, dest, user}.
- Pointers:
  - Pointers wrap from BUF_SIZE-1 to 0 by explicit compare, not modulo-2^n.
- Level counter:
  - +1 on push only, -1 on pop only, unchanged when push and pop occur together.
- Push and pop conditions:
  - push = src.t_valid && src.t_ready
  - pop = dest.t_valid && dest.t_ready
- src.t_ready = !areset && (level != BUF_SIZE). It is a registered-state function with no combinational path from dest.t_ready.
- When full, a simultaneous pop does not enable a push in the same cycle.
- Latency: a beat pushed in cycle N is visible on dest at cycle N+1 at the earliest. There is no empty bypass.
- dest payload is driven from the entry at the read pointer, valid whenever dest.t_valid is high.
- Cut-through mode (PKT_MODE=0): dest.t_valid = (level != 0).
- Store-and-forward mode (PKT_MODE=1):
  - pkt_count +1 on a push with t_last.
  - pkt_count -1 on a pop with t_last.
  - Both in the same cycle leave pkt_count unchanged.
  - dest.t_valid = (level != 0) && (pkt_count != 0 || flush).
- Flush flag (PKT_MODE=1 only):
  - Sets when level == BUF_SIZE && pkt_count == 0. This is the oversize-packet case.
  - Clears on a pop with t_last.
  - While flush is set, the buffer acts cut-through so the packet drains. This prevents deadlock.
- Once dest.t_valid is asserted it stays high until a pop occurs, per AXI-stream rules.
- Payload is stable while valid && !ready.
- level, pkt_count and almost_full are registered and reflect state after the previous edge.

Optional Feature:
- Macro: NASTI_STREAM_PKT_BUF_STATS_EN.
- When defined:
  - Adds outputs stat_beats[31:0] and stat_pkts[31:0].
  - stat_beats counts pops; stat_pkts counts pops with t_last.
  - Both are cleared by areset and wrap at 2^32.
- When undefined:
  - The ports and counters do not exist.
  - Behaviour is otherwise identical.

Decomposition:
- Package nasti_stream_pkg holds:
  - The parametrised beat struct helper (or the STRB_WIDTH = DATA_WIDTH/8 constant).
  - The function clog2p1(n) used for level widths.
- One sub-module, stream_ram_fifo, provides the storage array, wrapping pointers and level counter.
- The top-level handles packet accounting, flush, valid/ready and stats.

Test Plan:
- Reset then stream, PKT_MODE=0, BUF_SIZE=5:
  - Stimulus: push 5 beats with dest.t_ready=0.
  - Required: level 5, src.t_ready=0, almost_full=1 from level 3.
  - Then ready=1: beats emerge in order, one per cycle.
- Store-and-forward, PKT_MODE=1, BUF_SIZE=8:
  - Stimulus: push 3-beat packet A, with last on beat 3.
  - Required: dest.t_valid stays 0 until the cycle after beat 3 is accepted; pkt_count=1.
  - After the 3 pops: pkt_count=0 and valid drops.
- Oversize packet, PKT_MODE=1, BUF_SIZE=4:
  - Stimulus: push a 6-beat packet.
  - Required: at level 4 flush sets and valid rises. All 6 beats drain in order; flush clears after the last-beat pop.
- Simultaneous push/pop at level 2, random ready/valid, 1000 beats:
  - Required: level steady during concurrent traffic, zero loss or duplication vs scoreboard, payload stable under backpressure.
- Mid-packet reset:
  - Stimulus: areset high for 1 cycle with 3 beats stored.
  - Required: level=0, pkt_count=0, dest.t_valid=0. The next packet passes intact.
- STATS_EN defined:
  - Stimulus: 4 packets of 2 beats each.
  - Required: stat_beats=8, stat_pkts=4; both are 0 after areset.
